// File: rtl/cola_if_id.sv
// -----------------------------------------------------------------------------
// cola_if_id
//
// Instruction queue between the fetch stage and the decode stage. Each entry
// is a {pc_plus4, instruccion} pair held in a first-word-fall-through FIFO, so
// the oldest pair is always visible at the head outputs. Fetch and decode run
// decoupled; a synchronous flush empties the queue when a branch or jump is
// taken.
//
// Handshake (both sides): a transfer happens on a rising clk edge exactly when
// valid and ready are both high in the cycle before that edge. The producer
// keeps its data stable while valid is high and ready is low. ready never
// depends combinationally on valid on the same side, and vice versa.
//
// Ports
//   clk                rising-edge clock
//   rst_tb             asynchronous active-low reset
//   flush              synchronous discard of every entry (highest priority)
//   in_valid           fetch presents an instruction
//   in_ready           queue can accept (count != DEPTH)
//   instruccion_fetch  instruction from fetch
//   pc_plus4           PC+4 accompanying the instruction
//   out_valid          head entry valid (count != 0)
//   out_ready          decode consumes the head this cycle
//   instruccion_id     head instruction, 0 (NOP) when empty
//   pc_plus4_id        head PC+4, 0 when empty
//   count              current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module cola_if_id #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              rst_tb,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       instruccion_fetch,
   input  logic [31:0]       pc_plus4,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       instruccion_id,
   output logic [31:0]       pc_plus4_id,
   output logic [ADDR_W:0]   count
);

   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

   // Storage: {pc_plus4, instruccion}. Not reset; the head is gated while
   // empty so stale contents never reach decode.
   logic [63:0] mem [DEPTH];

   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count_q;

   logic push;
   logic pop;
   logic do_push;
   logic do_pop;

   // Status flags come from the registered count only, which keeps the
   // in_valid->out_valid and out_ready->in_ready paths free of logic.
   assign in_ready  = (count_q != FULL_CNT);
   assign out_valid = (count_q != '0);
   assign count     = count_q;

   assign push = in_valid  & in_ready;
   assign pop  = out_valid & out_ready;

   // Flush wins over any concurrent transfer.
   assign do_push = push & ~flush;
   assign do_pop  = pop  & ~flush;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= {pc_plus4, instruccion_fetch};
      end
   end

   always_ff @(posedge clk or negedge rst_tb) begin
      if (!rst_tb) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         // Pointers wrap through their natural ADDR_W-bit overflow.
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         unique case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

   // First-word-fall-through head; an entry written at an edge shows here
   // after that edge (no bypass from the fetch inputs).
   logic [63:0] head;

   always_comb begin
      head = '0;
      if (count_q != '0) begin
         head = mem[rd_ptr];
      end
   end

   assign pc_plus4_id    = head[63:32];
   assign instruccion_id = head[31:0];

endmodule

// File: tb/tb_cola_if_id.sv
module tb_cola_if_id;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_tb = 1'b0;
  always #5 clk = ~clk;

  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [31:0]       instruccion_fetch = '0;
  logic [31:0]       pc_plus4 = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       instruccion_id;
  logic [31:0]       pc_plus4_id;
  logic [ADDR_W:0]   count;

  cola_if_id #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk               (clk),
    .rst_tb            (rst_tb),
    .flush             (flush),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .instruccion_fetch (instruccion_fetch),
    .pc_plus4          (pc_plus4),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .instruccion_id    (instruccion_id),
    .pc_plus4_id       (pc_plus4_id),
    .count             (count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  // exp_q holds the {pc_plus4, instruction} pairs the queue must still deliver,
  // oldest first. Acceptance is decided from the model's own occupancy.
  logic [63:0] exp_q[$];

  // Monitor: samples just before each rising edge, when inputs are stable.
  always begin
    @(negedge clk);
    #4;
    if (!rst_tb) begin
      exp_q.delete();
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_head", {pc_plus4_id, instruccion_id}, 64'd0);
    end else begin
      int n;
      n = exp_q.size();
      chk("count", 64'(count), 64'(n));
      chk("out_valid", 64'(out_valid), 64'(n != 0));
      chk("in_ready", 64'(in_ready), 64'(n != DEPTH));
      if (n == 0)
        chk("empty_head", {pc_plus4_id, instruccion_id}, 64'd0);
      else
        chk("head", {pc_plus4_id, instruccion_id}, exp_q[0]);
      if (flush) begin
        exp_q.delete();
      end else begin
        if (out_ready && n != 0) void'(exp_q.pop_front());
        if (in_valid && n != DEPTH) exp_q.push_back({pc_plus4, instruccion_fetch});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic r, input logic f,
                       input logic [31:0] ins, input logic [31:0] pc);
    @(negedge clk);
    in_valid = v;
    out_ready = r;
    flush = f;
    instruccion_fetch = ins;
    pc_plus4 = pc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  logic [31:0] fill_ins [4];

  initial begin
    fill_ins[0] = 32'h2008_0005;
    fill_ins[1] = 32'h2009_0003;
    fill_ins[2] = 32'h0109_5020;
    fill_ins[3] = 32'hAC0A_0000;

    // reset for 2 cycles then idle
    repeat (2) @(negedge clk);
    rst_tb = 1'b1;
    idle(2);

    // fill, 5th push ignored, drain
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, fill_ins[i], 32'(4 * (i + 1)));
    drive(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'd20);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);

    // streaming from empty
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b0, 32'h1000_0000 + 32'(i), 32'(100 + 4 * i));
    idle(1);
    for (int i = 0; i < 2; i++) drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);

    // full with simultaneous pop, then pop+push
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 32'h3000_0000 + 32'(i), 32'(200 + 4 * i));
    drive(1'b1, 1'b1, 1'b0, 32'h3000_0010, 32'd300);
    drive(1'b1, 1'b1, 1'b0, 32'h3000_0010, 32'd300);

    // flush with concurrent push/pop, then a fresh head
    drive(1'b1, 1'b1, 1'b1, 32'h5555_5555, 32'd500);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0800_0010, 32'd40);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    idle(1);

    // interleaved push/pop so pointers wrap at least twice
    for (int i = 0; i < 12; i++)
      drive(1'b1, (i % 3) != 0, 1'b0, 32'h7000_0000 + 32'(i), 32'(600 + 4 * i));
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);

    // two entries then async reset mid-cycle
    drive(1'b1, 1'b0, 1'b0, 32'h9000_0001, 32'd900);
    drive(1'b1, 1'b0, 1'b0, 32'h9000_0002, 32'd904);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #2;
    rst_tb = 1'b0;
    #1;
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_head", {pc_plus4_id, instruccion_id}, 64'd0);
    @(negedge clk);
    rst_tb = 1'b1;
    idle(1);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 19) == 0), $urandom, $urandom);
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    idle(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
